// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    // Default operand/result width.
    localparam int unsigned DIV_WIDTH = 16;

    // Quotient reported on divide-by-zero (all ones), wide enough for any WIDTH up to 64.
    localparam logic [63:0] DIV0_Q = '1;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // WIDTH+1-bit trial so the shifted-out remainder MSB still takes part in the compare.
    always_comb begin
        trial    = {rem, dvd_msb};
        diff     = trial - {1'b0, div};
        q_bit    = (trial >= {1'b0, div});
        // Remainder stays below the divisor, so the low WIDTH bits hold it exactly.
        rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/div_16to16.sv
// Sequential restoring divider, one quotient bit per clock, fl_i start / fl_o done handshake.
// Compile option DIV_SIGNED_EN: two's-complement operands with truncating division.
module div_16to16
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             fl_i,
    output logic [WIDTH-1:0] Q_o,
    output logic [WIDTH-1:0] R_o,
    output logic             fl_o,
    output logic             busy_o,
    output logic             dz_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] rem;

    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH-1:0] rem_next_c;
    logic             q_bit_c;
    logic [WIDTH-1:0] quo_c;
    logic [WIDTH-1:0] q_fix_c;
    logic [WIDTH-1:0] r_fix_c;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Magnitudes at capture; results re-signed on entry to DONE.
    always_comb begin
        a_mag_c = A_i[WIDTH-1] ? WIDTH'(-A_i) : A_i;
        b_mag_c = B_i[WIDTH-1] ? WIDTH'(-B_i) : B_i;
        q_fix_c = neg_q ? WIDTH'(-quo_c) : quo_c;
        r_fix_c = neg_r ? WIDTH'(-rem_next_c) : rem_next_c;
    end
`else
    // Unsigned build: operands and results pass straight through.
    always_comb begin
        a_mag_c = A_i;
        b_mag_c = B_i;
        q_fix_c = quo_c;
        r_fix_c = rem_next_c;
    end
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[WIDTH-1]),
        .div      (div),
        .rem_next (rem_next_c),
        .q_bit    (q_bit_c)
    );

    // Quotient bits fill the dividend register from the LSB as it shifts out.
    assign quo_c = {dvd[WIDTH-2:0], q_bit_c};

    // Control FSM and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            cnt    <= '0;
            dvd    <= '0;
            div    <= '0;
            rem    <= '0;
            Q_o    <= '0;
            R_o    <= '0;
            fl_o   <= 1'b0;
            busy_o <= 1'b0;
            dz_o   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            fl_o <= (state == DONE);
            case (state)
                CALC: begin
                    dvd <= quo_c;
                    rem <= rem_next_c;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        Q_o    <= q_fix_c;
                        R_o    <= r_fix_c;
                        dz_o   <= 1'b0;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new start, giving back-to-back operation.
                    state <= IDLE;
                    if (fl_i) begin
                        dvd <= a_mag_c;
                        div <= b_mag_c;
                        rem <= '0;
`ifdef DIV_SIGNED_EN
                        neg_q <= A_i[WIDTH-1] ^ B_i[WIDTH-1];
                        neg_r <= A_i[WIDTH-1];
`endif
                        if (B_i != '0) begin
                            state  <= CALC;
                            cnt    <= CNT_W'(WIDTH - 1);
                            busy_o <= 1'b1;
                        end else begin
                            state <= DONE;
                            Q_o   <= WIDTH'(DIV0_Q);
                            R_o   <= A_i;
                            dz_o  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
